// File: rtl/oops_structs.sv
// Shared types and constants for the 64-bit burst pmem interface.
// Holds the responder state encoding, the burst geometry and the line type.
package oops_structs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } pmem_state_e;

  localparam int unsigned PMEM_BURST_LEN = 4;
  localparam int unsigned PMEM_BEAT_W    = 64;
  localparam int unsigned PMEM_LINE_W    = 256;

  typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

endpackage

// File: rtl/oops_lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, advanced on demand.
// Ports: clk, rst (async active-high, loads seed), seed[7:0], step, value[7:0].
module oops_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  // Right-shifting Galois form; 8'hB8 is the tap mask for bits 8,6,5,4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (step) begin
      value <= {1'b0, value[7:1]} ^ (value[0] ? 8'hB8 : 8'h00);
    end
  end

endmodule

// File: rtl/pmem_burst_responder.sv
// Physical-memory responder: serves 32-byte line reads/writes as 4 x 64-bit
// beats after a programmable latency, backed by an internal line array.
// Ports: clk, rst (async active-high), pmem_read, pmem_write, pmem_addr[31:0],
//        pmem_wdata[63:0] in; pmem_resp, pmem_rdata[63:0], busy_o, err_o out.
// Optional: define PMEM_RANDOM_LATENCY_EN to add 0..7 LFSR-driven extra
//           wait cycles per request (seeded with JITTER_SEED).
module pmem_burst_responder
  import oops_structs::*;
#(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 256,
  parameter logic [7:0]  JITTER_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_addr,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
  localparam int unsigned CNT_W = 9;  // LATENCY (<=255) plus up to 7 jitter cycles

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_BURST = 2'(BURST);
  localparam logic [1:0] ST_DONE  = 2'(DONE);
  localparam logic [1:0] LAST_BEAT = 2'(PMEM_BURST_LEN - 1);

  pmem_line_t mem [DEPTH_LINES];

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       beat, beat_n, beat_inc;
  logic             op_write, op_write_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             resp_n, busy_n, err_n;
  logic [63:0]      rdata_n;
  logic             req_c;
  logic             mem_we_c;
  logic             accept_c;
  logic [CNT_W-1:0] wait_load_c;

  // Address bits outside the line index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{pmem_addr[31:5+IDX_W], pmem_addr[4:0]};

`ifdef PMEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_value;

  oops_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (JITTER_SEED),
    .step  (accept_c),
    .value (lfsr_value)
  );

  assign wait_load_c = CNT_W'(LATENCY) + CNT_W'(lfsr_value[2:0]);
`else
  logic unused_jitter;
  assign unused_jitter = ^{JITTER_SEED, accept_c};
  assign wait_load_c   = CNT_W'(LATENCY);
`endif

  // The request line belonging to the latched operation.
  assign req_c    = op_write ? pmem_write : pmem_read;
  assign beat_inc = beat + 2'd1;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      beat       <= '0;
      op_write   <= 1'b0;
      idx        <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      beat       <= beat_n;
      op_write   <= op_write_n;
      idx        <= idx_n;
      pmem_resp  <= resp_n;
      pmem_rdata <= rdata_n;
      busy_o     <= busy_n;
      err_o      <= err_n;
    end
  end

  // Backing array write port; not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx][32'(beat) * PMEM_BEAT_W +: PMEM_BEAT_W] <= pmem_wdata;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    beat_n     = beat;
    op_write_n = op_write;
    idx_n      = idx;
    resp_n     = 1'b0;
    rdata_n    = pmem_rdata;
    err_n      = err_o;
    mem_we_c   = 1'b0;
    accept_c   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pmem_read && pmem_write) begin
          err_n = 1'b1;
        end else if (pmem_read || pmem_write) begin
          accept_c   = 1'b1;
          op_write_n = pmem_write;
          idx_n      = pmem_addr[5 +: IDX_W];
          cnt_n      = wait_load_c;
          state_n    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_c) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          state_n = ST_BURST;
          beat_n  = 2'd0;
          resp_n  = 1'b1;
          if (!op_write) rdata_n = mem[idx][0 +: PMEM_BEAT_W];
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_BURST: begin
        // A dropped request is flagged but the burst still runs to completion.
        if (!req_c) err_n = 1'b1;
        mem_we_c = op_write;
        if (beat == LAST_BEAT) begin
          state_n = ST_DONE;
        end else begin
          beat_n = beat_inc;
          resp_n = 1'b1;
          if (!op_write) rdata_n = mem[idx][32'(beat_inc) * PMEM_BEAT_W +: PMEM_BEAT_W];
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed self-checking bench for pmem_burst_responder.
module tb_pmem_burst_responder;

  localparam int unsigned LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_addr = '0;
  logic [63:0] pmem_wdata = '0;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        busy_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] line_a;

  pmem_burst_responder #(
    .LATENCY     (LATENCY),
    .DEPTH_LINES (256),
    .JITTER_SEED (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_resp  (pmem_resp),
    .pmem_rdata (pmem_rdata),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

`ifdef PMEM_RANDOM_LATENCY_EN
  logic [7:0] model_lfsr = 8'hA5;
`endif

  // Expected first-beat delay for the next accepted request.
  task automatic next_delay(output int d);
`ifdef PMEM_RANDOM_LATENCY_EN
    d = int'(LATENCY) + 1 + int'(model_lfsr[2:0]);
    model_lfsr = {1'b0, model_lfsr[7:1]} ^ (model_lfsr[0] ? 8'hB8 : 8'h00);
`else
    d = int'(LATENCY) + 1;
`endif
  endtask

  task automatic model_reseed();
`ifdef PMEM_RANDOM_LATENCY_EN
    model_lfsr = 8'hA5;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full burst as the initiator and reports what was observed.
  // first = edge index (accept edge = 0) of the first resp cycle.
  task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [255:0] wline,
                           output logic [255:0] rline, output int first, output int nbeats,
                           output logic contig, output logic busy_all);
    int cyc;
    rline = '0; first = -1; nbeats = 0; contig = 1'b1; busy_all = 1'b1;
    pmem_addr = addr; pmem_write = wr; pmem_read = !wr;
    tick();
    cyc = 0;
    if (!busy_o) busy_all = 1'b0;
    while (nbeats < 4 && cyc < 64) begin
      tick();
      cyc++;
      if (!busy_o) busy_all = 1'b0;
      if (pmem_resp) begin
        if (first < 0) first = cyc;
        else if (cyc != first + nbeats) contig = 1'b0;
        rline[nbeats*64 +: 64] = pmem_rdata;
        pmem_wdata = wline[nbeats*64 +: 64];
        nbeats++;
      end
    end
    tick();  // edge closing the last beat: DONE
    if (pmem_resp) contig = 1'b0;
    if (!busy_o) busy_all = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0;
    tick();  // back to IDLE
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reseed();
    tick();
    n_checks++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %b want 0", pmem_resp); end
    n_checks++; if (pmem_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", pmem_rdata); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
  endtask

  task automatic test_write_read();
    logic [255:0] rl; int first, nb, d; logic contig, ball;
    next_delay(d);
    run_burst(1'b1, 32'h0000_0040, line_a, rl, first, nb, contig, ball);
    n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL wr_beats got %0d want 4", nb); end
    n_checks++; if (first !== d) begin n_fail++; $display("FAIL wr_first_cycle got %0d want %0d", first, d); end
    n_checks++; if (contig !== 1'b1) begin n_fail++; $display("FAIL wr_contiguous got %b want 1", contig); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", err_o); end
    next_delay(d);
    run_burst(1'b0, 32'h0000_0040, '0, rl, first, nb, contig, ball);
    n_checks++; if (rl !== line_a) begin n_fail++; $display("FAIL rd_data got %h want %h", rl, line_a); end
    n_checks++; if (first !== d) begin n_fail++; $display("FAIL rd_first_cycle got %0d want %0d", first, d); end
    n_checks++; if (contig !== 1'b1) begin n_fail++; $display("FAIL rd_contiguous got %b want 1", contig); end
  endtask

  task automatic test_addr_wrap();
    logic [255:0] rl; int first, nb, d; logic contig, ball;
    next_delay(d);
    run_burst(1'b0, 32'h0000_2040, '0, rl, first, nb, contig, ball);
    n_checks++; if (rl !== line_a) begin n_fail++; $display("FAIL wrap_data got %h want %h", rl, line_a); end
    n_checks++; if (ball !== 1'b1) begin n_fail++; $display("FAIL wrap_busy_span got %b want 1", ball); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_after got %b want 0", busy_o); end
  endtask

  task automatic test_both_high();
    logic saw_resp;
    saw_resp = 1'b0;
    pmem_addr = 32'h0000_0040; pmem_read = 1'b1; pmem_write = 1'b1;
    tick();
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL both_err got %b want 1", err_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL both_busy got %b want 0", busy_o); end
    for (int i = 0; i < 8; i++) begin
      if (pmem_resp) saw_resp = 1'b1;
      tick();
    end
    n_checks++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL both_resp got %b want 0", saw_resp); end
    pmem_read = 1'b0; pmem_write = 1'b0;
    tick();
  endtask

  task automatic test_wait_drop();
    logic saw_resp; int d;
    saw_resp = 1'b0;
    next_delay(d);
    pmem_addr = 32'h0000_0040; pmem_read = 1'b1;
    tick();  // accept edge
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drop_busy_wait got %b want 1", busy_o); end
    tick(); tick();
    pmem_read = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pmem_resp) saw_resp = 1'b1;
    end
    n_checks++; if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL drop_resp got %b want 0", saw_resp); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b want 1 (d=%0d)", err_o, d); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drop_busy_idle got %b want 0", busy_o); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rl; int first, nb, d, seen, cyc; logic contig, ball;
    test_reset();
    next_delay(d);
    pmem_addr = 32'h0000_0040; pmem_read = 1'b1;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 64) begin
      tick();
      cyc++;
      if (pmem_resp) seen++;
    end
    n_checks++; if (seen !== 2) begin n_fail++; $display("FAIL midrst_reach_burst got %0d beats want 2", seen); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (pmem_resp !== 1'b0) begin n_fail++; $display("FAIL midrst_resp got %b want 0", pmem_resp); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_o); end
    pmem_read = 1'b0;
    tick();
    rst = 1'b0;
    model_reseed();
    tick();
    next_delay(d);
    run_burst(1'b0, 32'h0000_0040, '0, rl, first, nb, contig, ball);
    n_checks++; if (rl !== line_a) begin n_fail++; $display("FAIL midrst_data got %h want %h", rl, line_a); end
    n_checks++; if (first !== d) begin n_fail++; $display("FAIL midrst_first_cycle got %0d want %0d", first, d); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", err_o); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] rl; int first, nb, d; logic contig, ball;
    for (int i = 0; i < 8; i++) begin
      next_delay(d);
      run_burst(1'b0, (i % 2 == 0) ? 32'h0000_0040 : 32'hFFFF_E04C, '0, rl, first, nb, contig, ball);
      n_checks++;
      if (first !== d || rl !== line_a) begin
        n_fail++;
        $display("FAIL b2b_%0d first got %0d want %0d data got %h want %h", i, first, d, rl, line_a);
      end
    end
  endtask

  initial begin
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    test_reset();
    test_write_read();
    test_addr_wrap();
    test_both_high();
    test_wait_drop();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
